aes_stream_decipher: RTL

Receive-side counterpart of the team's byte-stream AES inverse-S-box cipher. It regenerates the same keystream, keystream byte n = INV_SBOX[(key + n) mod 256], and XORs it onto incoming cipher bytes to recover plaintext. Unlike the cipher, it frames messages with an explicit length and has valid/ready handshakes on both sides. The keystream advances only on accepted bytes, so it tolerates gaps and backpressure.

---
 rtl/aes_stream_decipher.sv | 126 ++++++++++++
 1 files changed

// File: rtl/aes_stream_decipher.sv
// rtl/aes_stream_decipher.sv - length-framed AES inverse-S-box keystream decipher
// Single output register with valid/ready on both sides; keystream advances per accepted byte.
module aes_stream_decipher #(
  parameter int LEN_W = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic [7:0]       i_key,
  input  logic [LEN_W-1:0] i_msg_len,
  input  logic             i_s_valid,
  output logic             o_s_ready,
  input  logic [7:0]       i_s_data,
  output logic             o_m_valid,
  input  logic             i_m_ready,
  output logic [7:0]       o_m_data,
  output logic             o_m_last,
  output logic             o_busy,
  output logic             o_done,
  output logic [7:0]       o_ks_index
);

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // One extra counter bit so msg_len=0 can be held as the full 2^LEN_W count.
  localparam logic [LEN_W:0] REM_ONE  = (LEN_W+1)'(1);
  localparam logic [LEN_W:0] REM_FULL = REM_ONE << LEN_W;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t         r_state;
  logic [LEN_W:0] r_remaining;
  logic [7:0]     r_ks_index;
  logic [7:0]     r_m_data;
  logic           r_m_valid;
  logic           r_m_last;
  logic           r_busy;
  logic           r_done;

  logic w_s_ready;
  logic w_accept;
  logic w_m_hs;

  assign w_s_ready = (r_state == RUN) && !i_start && (r_remaining != '0)
                     && (!r_m_valid || i_m_ready);
  assign w_accept  = i_s_valid && w_s_ready;
  assign w_m_hs    = r_m_valid && i_m_ready;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_ks_index  <= 8'h00;
      r_m_data    <= 8'h00;
      r_m_valid   <= 1'b0;
      r_m_last    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        // A start while busy aborts: any pending output byte is discarded silently.
        r_state     <= RUN;
        r_ks_index  <= i_key;
        r_remaining <= (i_msg_len == '0) ? REM_FULL : {1'b0, i_msg_len};
        r_busy      <= 1'b1;
        r_m_valid   <= 1'b0;
        r_m_last    <= 1'b0;
      end else begin
        case (r_state)
          RUN: begin
            if (w_accept) begin
              r_m_data    <= i_s_data ^ INV_SBOX[r_ks_index];
              r_m_valid   <= 1'b1;
              r_m_last    <= (r_remaining == REM_ONE);
              r_ks_index  <= r_ks_index + 8'd1;
              r_remaining <= r_remaining - REM_ONE;
              if (r_remaining == REM_ONE) begin
                r_state <= DRAIN;
              end
            end else if (w_m_hs) begin
              r_m_valid <= 1'b0;
            end
          end
          DRAIN: begin
            if (w_m_hs) begin
              r_m_valid <= 1'b0;
              r_m_last  <= 1'b0;
              r_done    <= 1'b1;
              r_busy    <= 1'b0;
              r_state   <= IDLE;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign o_s_ready  = w_s_ready;
  assign o_m_valid  = r_m_valid;
  assign o_m_data   = r_m_data;
  assign o_m_last   = r_m_last;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_ks_index = r_ks_index;

endmodule
